// File: rtl/ibex_muldiv_iter.sv
// Iterative 32-bit multiply/divide unit: one radix-2 step per cycle, 32 steps per op,
// followed by a sign-fix cycle and a one-cycle result pulse.
module ibex_muldiv_iter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  operator_i,
  input  logic [1:0]  signed_mode_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  output logic        valid_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e      state, state_next;
  logic [1:0]  op_q;
  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [4:0]  cnt;
  logic [63:0] prod;
  logic [31:0] quot, rem;

  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
    logic signed [31:0] s;
    s = signed'(v);
    return neg ? unsigned'(-s) : v;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
    logic signed [63:0] s;
    s = signed'(v);
    return neg ? unsigned'(-s) : v;
  endfunction

  logic neg_a_in, neg_b_in, accept, div_zero;
  assign neg_a_in = signed_mode_i[0] & op_a_i[31];
  assign neg_b_in = signed_mode_i[1] & op_b_i[31];
  assign accept   = (state == IDLE) & valid_i & ~kill_i;
  assign div_zero = operator_i[1] & (op_b_i == 32'd0);

  // One step per cycle, MSB first: bit cnt of the multiplier / dividend enters this step.
  logic [63:0] prod_next;
  logic [32:0] trial, sub;
  logic        ge;
  assign prod_next = (prod << 1) + {32'd0, mag_a & {32{mag_b[cnt]}}};
  assign trial     = {rem, mag_a[cnt]};
  assign sub       = trial - {1'b0, mag_b};
  assign ge        = ~sub[32];

  logic [63:0] prod_fix;
  logic [31:0] result_fix;
  always_comb begin
    prod_fix = cneg64(prod, sign_a ^ sign_b);
    case (op_q)
      2'd0:    result_fix = prod_fix[31:0];
      2'd1:    result_fix = prod_fix[63:32];
      2'd2:    result_fix = cneg32(quot, sign_a ^ sign_b);
      default: result_fix = cneg32(rem, sign_a);
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = div_zero ? DONE : CALC;
      CALC: begin
        if (kill_i)          state_next = IDLE;
        else if (cnt == 5'd0) state_next = FIX;
      end
      FIX:  state_next = kill_i ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state == IDLE);
    valid_o = (state == DONE) & ~kill_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= 2'd0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      mag_a    <= 32'd0;
      mag_b    <= 32'd0;
      cnt      <= 5'd0;
      prod     <= 64'd0;
      quot     <= 32'd0;
      rem      <= 32'd0;
      result_o <= 32'd0;
    end else if (accept) begin
      op_q   <= operator_i;
      sign_a <= neg_a_in;
      sign_b <= neg_b_in;
      mag_a  <= cneg32(op_a_i, neg_a_in);
      mag_b  <= cneg32(op_b_i, neg_b_in);
      cnt    <= 5'd31;
      prod   <= 64'd0;
      quot   <= 32'd0;
      rem    <= 32'd0;
      // Divide-by-zero skips the iteration entirely and answers straight away.
      if (div_zero) result_o <= operator_i[0] ? op_a_i : 32'hFFFF_FFFF;
    end else if (state == CALC) begin
      cnt <= cnt - 5'd1;
      if (op_q[1]) begin
        rem  <= ge ? sub[31:0] : trial[31:0];
        quot <= {quot[30:0], ge};
      end else begin
        prod <= prod_next;
      end
    end else if (state == FIX) begin
      result_o <= result_fix;
    end
  end

endmodule

// File: tb/tb_ibex_muldiv_iter.sv
// Randomised and directed bench for ibex_muldiv_iter against a plain-arithmetic
// reference of multiply / divide semantics, with cycle-exact result timing.
module tb_ibex_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [1:0]  operator_i = 2'd0;
  logic [1:0]  signed_mode_i = 2'd0;
  logic [31:0] op_a_i = 32'd0;
  logic [31:0] op_b_i = 32'd0;
  logic        kill_i = 1'b0;
  logic        valid_o;
  logic [31:0] result_o;

  ibex_muldiv_iter dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .operator_i(operator_i), .signed_mode_i(signed_mode_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .kill_i(kill_i),
    .valid_o(valid_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail = 0;
  logic        pending = 1'b0;
  int          exp_cyc = 0;
  logic [31:0] exp_res = 32'd0;
  logic [31:0] last_res = 32'd0;
  logic        mon_ev;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: extend operands per signedness, then use full-width integer arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [1:0] mode,
                                         input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, t;
    logic [31:0] r;
    sa = mode[0] ? longint'(signed'(a)) : longint'(a);
    sb = mode[1] ? longint'(signed'(b)) : longint'(b);
    t  = 0;
    case (op)
      2'd0: begin t = sa * sb; r = t[31:0]; end
      2'd1: begin t = sa * sb; r = t[63:32]; end
      2'd2: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else begin t = sa / sb; r = t[31:0]; end
      end
      default: begin
        if (b == 32'd0) r = a;
        else begin t = sa % sb; r = t[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = $urandom_range(0, 15);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Called just after a rising edge while the DUT is idle.
  task automatic start_op(input logic [1:0] op, input logic [1:0] mode,
                          input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1;
    operator_i = op;
    signed_mode_i = mode;
    op_a_i = a;
    op_b_i = b;
    exp_res = model(op, mode, a, b);
    exp_cyc = cyc + ((op[1] && b == 32'd0) ? 1 : 34);
    pending = 1'b1;
  endtask

  // Busy-time inputs are random garbage that must be ignored.
  task automatic wait_done();
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!ready_o && n < 60) begin
      valid_i = $urandom_range(0, 1);
      operator_i = $urandom_range(0, 3);
      signed_mode_i = $urandom_range(0, 3);
      op_a_i = $urandom;
      op_b_i = $urandom;
      @(posedge clk); #1;
      n++;
    end
    valid_i = 1'b0;
    if (!ready_o) check("ready_timeout", {31'd0, ready_o}, 32'd1);
    pending = 1'b0;
  endtask

  task automatic run(input logic [1:0] op, input logic [1:0] mode,
                     input logic [31:0] a, input logic [31:0] b);
    start_op(op, mode, a, b);
    wait_done();
  endtask

  initial begin
    vecs[0]  = '{2'd0, 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
    vecs[1]  = '{2'd1, 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
    vecs[2]  = '{2'd0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[3]  = '{2'd1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[4]  = '{2'd1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5]  = '{2'd2, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    vecs[6]  = '{2'd3, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[7]  = '{2'd2, 2'b00, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003};
    vecs[8]  = '{2'd2, 2'b00, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[9]  = '{2'd3, 2'b00, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
    vecs[10] = '{2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

    // Per-cycle output checker: valid_o exactly on the expected cycle, result held otherwise.
    fork
      forever begin
        @(negedge clk);
        if (!rst_ni) last_res = 32'd0;
        else begin
          mon_ev = pending && (cyc == exp_cyc);
          check("valid_o", {31'd0, valid_o}, {31'd0, mon_ev});
          if (mon_ev) begin
            check("result_o", result_o, exp_res);
            last_res = exp_res;
          end else if (!pending) begin
            check("result_hold", result_o, last_res);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, ready_o}, 32'd1);
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      check($sformatf("model_pin%0d", i), model(vecs[i].op, vecs[i].mode, vecs[i].a, vecs[i].b),
            vecs[i].res);
      run(vecs[i].op, vecs[i].mode, vecs[i].a, vecs[i].b);
    end

    // Kill on the 10th CALC cycle, then a back-to-back op.
    start_op(2'd2, 2'b11, 32'h1234_5678, 32'h0000_0013);
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    kill_i = 1'b1;
    pending = 1'b0;
    @(posedge clk); #1;
    kill_i = 1'b0;
    check("kill_ready", {31'd0, ready_o}, 32'd1);
    run(2'd1, 2'b11, 32'h8765_4321, 32'h0BAD_F00D);

    // Asynchronous reset in the middle of CALC.
    start_op(2'd0, 2'b00, 32'hDEAD_BEEF, 32'h0000_0101);
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2;
    rst_ni = 1'b0;
    pending = 1'b0;
    #1;
    check("async_rst_ready", {31'd0, ready_o}, 32'd1);
    check("async_rst_valid", {31'd0, valid_o}, 32'd0);
    check("async_rst_result", result_o, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    run(2'd3, 2'b00, 32'hFFFF_FFF0, 32'h0000_0007);

    for (int k = 0; k < 40; k++) begin
      run(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), pick(), pick());
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
